// File: rtl/spell_mem_arbiter_pkg.sv
// Shared definitions for the spell memory arbiter: FSM encoding and memory type helpers.
// Reuses `MemoryTypeCode / `MemoryTypeData when the surrounding build already provides them.
`ifndef MemoryTypeCode
`define MemoryTypeCode 2'b00
`endif
`ifndef MemoryTypeData
`define MemoryTypeData 2'b01
`endif

package spell_mem_arbiter_pkg;

  localparam logic [1:0] SPELL_ARB_IDLE   = 2'd0;
  localparam logic [1:0] SPELL_ARB_ACCESS = 2'd1;
  localparam logic [1:0] SPELL_ARB_RESP   = 2'd2;

  function automatic logic mem_type_valid(input logic [1:0] mem_type);
    return (mem_type == `MemoryTypeCode) || (mem_type == `MemoryTypeData);
  endfunction

endpackage

// File: rtl/spell_mem_arbiter_if.sv
// Bus bundle for the spell memory arbiter: two requester ports plus the spell_mem port.
// The master modport is the arbiter; the slave modport is the requesters and memory side.
interface spell_mem_arbiter_if;

  logic       rq0_req,   rq1_req;
  logic [7:0] rq0_addr,  rq1_addr;
  logic [7:0] rq0_wdata, rq1_wdata;
  logic [1:0] rq0_type,  rq1_type;
  logic       rq0_write, rq1_write;
  logic [7:0] rq0_rdata, rq1_rdata;
  logic       rq0_ready, rq1_ready;
  logic       rq0_err,   rq1_err;

  logic       mem_select;
  logic       mem_write;
  logic [7:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [1:0] mem_memory_type;
  logic [7:0] mem_data_out;
  logic       mem_data_ready;

  modport master (
    input  rq0_req, rq0_addr, rq0_wdata, rq0_type, rq0_write,
    input  rq1_req, rq1_addr, rq1_wdata, rq1_type, rq1_write,
    output rq0_rdata, rq0_ready, rq0_err,
    output rq1_rdata, rq1_ready, rq1_err,
    output mem_select, mem_write, mem_addr, mem_data_in, mem_memory_type,
    input  mem_data_out, mem_data_ready
  );

  modport slave (
    output rq0_req, rq0_addr, rq0_wdata, rq0_type, rq0_write,
    output rq1_req, rq1_addr, rq1_wdata, rq1_type, rq1_write,
    input  rq0_rdata, rq0_ready, rq0_err,
    input  rq1_rdata, rq1_ready, rq1_err,
    input  mem_select, mem_write, mem_addr, mem_data_in, mem_memory_type,
    output mem_data_out, mem_data_ready
  );

endinterface

// File: rtl/spell_mem_arb_rr.sv
// Combinational two-way round-robin picker: on contention the port not granted last wins.
module spell_mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    grant_valid = |req;
    grant_idx   = 1'b0;
    case (req)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Two-port arbiter/sequencer for spell_mem: grants one requester, holds the registered bus
// until mem_data_ready, then pulses ready. Optional ACCESS timeout: SPELL_MEM_ARB_TIMEOUT_EN.
module spell_mem_arbiter
  import spell_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  spell_mem_arbiter_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("spell_mem_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  logic [1:0] state_q;
  logic       last_grant_q;
  logic       granted_q;
  logic       mem_select_q;
  logic       mem_write_q;
  logic [7:0] mem_addr_q;
  logic [7:0] mem_data_in_q;
  logic [1:0] mem_type_q;
  logic [7:0] rdata_q [2];
  logic [1:0] ready_q;
  logic [1:0] err_q;

  logic       grant_valid;
  logic       grant_idx;
  logic [7:0] sel_addr;
  logic [7:0] sel_wdata;
  logic [1:0] sel_type;
  logic       sel_write;
  logic       timeout_hit;

  spell_mem_arb_rr u_rr (
    .req         ({bus.rq1_req, bus.rq0_req}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign sel_addr  = grant_idx ? bus.rq1_addr  : bus.rq0_addr;
  assign sel_wdata = grant_idx ? bus.rq1_wdata : bus.rq0_wdata;
  assign sel_type  = grant_idx ? bus.rq1_type  : bus.rq0_type;
  assign sel_write = grant_idx ? bus.rq1_write : bus.rq0_write;

`ifdef SPELL_MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];
  logic [7:0] tmo_cnt_q;

  // Clearing while IDLE guarantees a zero count on every entry into ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SPELL_ARB_IDLE) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SPELL_ARB_ACCESS) begin
      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end
  end

  assign timeout_hit = (state_q == SPELL_ARB_ACCESS) && ((tmo_cnt_q + 8'd1) == TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SPELL_ARB_IDLE;
      last_grant_q  <= 1'b1;
      granted_q     <= 1'b0;
      mem_select_q  <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_type_q    <= '0;
      // NOTE: the two-entry rdata array is visible state at reset, so it is cleared here too.
      rdata_q       <= '{default: '0};
      ready_q       <= '0;
      err_q         <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        SPELL_ARB_IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_idx;
            granted_q    <= grant_idx;
            if (mem_type_valid(sel_type)) begin
              mem_select_q  <= 1'b1;
              mem_write_q   <= sel_write;
              mem_addr_q    <= sel_addr;
              mem_data_in_q <= sel_wdata;
              mem_type_q    <= sel_type;
              state_q       <= SPELL_ARB_ACCESS;
            end else begin
              // Bad type never touches the memory; answer directly with an error.
              ready_q[grant_idx] <= 1'b1;
              err_q[grant_idx]   <= 1'b1;
              rdata_q[grant_idx] <= '0;
              state_q            <= SPELL_ARB_RESP;
            end
          end
        end
        SPELL_ARB_ACCESS: begin
          if (bus.mem_data_ready) begin
            mem_select_q       <= 1'b0;
            ready_q[granted_q] <= 1'b1;
            err_q[granted_q]   <= 1'b0;
            if (!mem_write_q) begin
              rdata_q[granted_q] <= bus.mem_data_out;
            end
            state_q <= SPELL_ARB_RESP;
          end else if (timeout_hit) begin
            mem_select_q       <= 1'b0;
            ready_q[granted_q] <= 1'b1;
            err_q[granted_q]   <= 1'b1;
            rdata_q[granted_q] <= '0;
            state_q            <= SPELL_ARB_RESP;
          end
        end
        SPELL_ARB_RESP: state_q <= SPELL_ARB_IDLE;
        default:        state_q <= SPELL_ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_select      = mem_select_q;
  assign bus.mem_write       = mem_write_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_data_in     = mem_data_in_q;
  assign bus.mem_memory_type = mem_type_q;
  assign bus.rq0_rdata       = rdata_q[0];
  assign bus.rq1_rdata       = rdata_q[1];
  assign bus.rq0_ready       = ready_q[0];
  assign bus.rq1_ready       = ready_q[1];
  assign bus.rq0_err         = err_q[0];
  assign bus.rq1_err         = err_q[1];

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed bench for spell_mem_arbiter: reset, reads, contention, write latency, bad type,
// optional timeout (SPELL_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) and mid-transaction reset.
module tb_spell_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  spell_mem_arbiter_if bus ();

  spell_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_idle();
    bus.rq0_req = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    bus.rq1_req = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0; bus.rq1_type = 2'b01; bus.rq1_write = 1'b0;
    bus.mem_data_out = '0; bus.mem_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] snap;
    snap = {bus.mem_select, bus.mem_write, bus.mem_addr, bus.mem_data_in, bus.mem_memory_type,
            bus.rq0_rdata, bus.rq1_rdata, bus.rq0_ready, bus.rq1_ready, bus.rq0_err, bus.rq1_err};
    n_cmp++;
    if (snap !== 40'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", snap, 40'd0);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (bus.mem_select !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_select: got %b want 0", bus.mem_select);
    end
  endtask

  task automatic test_single_read();
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h10; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.mem_addr, bus.mem_memory_type, bus.mem_write, bus.rq0_ready} !== {1'b1, 8'h10, 2'b01, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL read_grant: got sel=%b addr=%h type=%b wr=%b rdy=%b want 1 10 01 0 0",
                        bus.mem_select, bus.mem_addr, bus.mem_memory_type, bus.mem_write, bus.rq0_ready);
    end
    bus.mem_data_ready = 1'b1; bus.mem_data_out = 8'hA5;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata, bus.rq1_ready} !== {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0}) begin
      n_bad++; $display("FAIL read_resp: got sel=%b rdy=%b err=%b rdata=%h rdy1=%b want 0 1 0 a5 0",
                        bus.mem_select, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata, bus.rq1_ready);
    end
    bus.rq0_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
    n_cmp++;
    if (bus.rq0_ready !== 1'b0) begin
      n_bad++; $display("FAIL read_pulse: ready got %b want 0", bus.rq0_ready);
    end
  endtask

  task automatic test_contention();
    int order[$];
    int done_cnt[2];
    int last_cyc;
    done_cnt[0] = 0; done_cnt[1] = 0; last_cyc = 0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h20; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    bus.rq1_req = 1'b1; bus.rq1_addr = 8'h30; bus.rq1_type = 2'b01; bus.rq1_write = 1'b0;
    for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
      bus.mem_data_ready = bus.mem_select;
      bus.mem_data_out   = ~bus.mem_addr;
      tick();
      n_cmp++;
      if (bus.rq0_ready && bus.rq1_ready) begin
        n_bad++; $display("FAIL rr_both_ready: got both ready high at cycle %0d want one", cyc);
      end
      if (bus.rq0_ready || bus.rq1_ready) begin
        int idx;
        logic [7:0] exp_rd;
        logic [7:0] got_rd;
        idx    = bus.rq1_ready ? 1 : 0;
        exp_rd = (idx == 1) ? 8'hCF : 8'hDF;
        got_rd = (idx == 1) ? bus.rq1_rdata : bus.rq0_rdata;
        n_cmp++;
        if (got_rd !== exp_rd) begin
          n_bad++; $display("FAIL rr_rdata%0d: got %h want %h", idx, got_rd, exp_rd);
        end
        if (order.size() > 0) begin
          n_cmp++;
          if (cyc - last_cyc != 3) begin
            n_bad++; $display("FAIL rr_spacing: got %0d cycles between readies want 3", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        order.push_back(idx);
        done_cnt[idx]++;
        if (done_cnt[idx] == 2) begin
          if (idx == 0) bus.rq0_req = 1'b0;
          else          bus.rq1_req = 1'b0;
        end
      end
    end
    bus.mem_data_ready = 1'b0;
    n_cmp++;
    if (order.size() != 4) begin
      n_bad++; $display("FAIL rr_count: got %0d grants want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (order[i] != i % 2) begin
          n_bad++; $display("FAIL rr_order[%0d]: got port %0d want port %0d", i, order[i], i % 2);
        end
      end
    end
    bus.rq0_req = 1'b0; bus.rq1_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write_latency();
    bus.rq1_req = 1'b1; bus.rq1_addr = 8'h42; bus.rq1_wdata = 8'h3C; bus.rq1_type = 2'b00; bus.rq1_write = 1'b1;
    tick();
    bus.rq1_addr = 8'h99; bus.rq1_wdata = 8'h00; bus.rq1_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus.mem_select, bus.mem_addr, bus.mem_data_in, bus.mem_write, bus.mem_memory_type, bus.rq1_ready} !==
          {1'b1, 8'h42, 8'h3C, 1'b1, 2'b00, 1'b0}) begin
        n_bad++; $display("FAIL wr_hold[%0d]: got sel=%b addr=%h din=%h wr=%b type=%b rdy=%b want 1 42 3c 1 00 0", i,
                          bus.mem_select, bus.mem_addr, bus.mem_data_in, bus.mem_write, bus.mem_memory_type, bus.rq1_ready);
      end
      if (i == 3) bus.mem_data_ready = 1'b1;
      tick();
    end
    n_cmp++;
    if ({bus.mem_select, bus.rq1_ready, bus.rq1_err, bus.rq1_rdata} !== {1'b0, 1'b1, 1'b0, 8'hCF}) begin
      n_bad++; $display("FAIL wr_resp: got sel=%b rdy=%b err=%b rdata=%h want 0 1 0 cf",
                        bus.mem_select, bus.rq1_ready, bus.rq1_err, bus.rq1_rdata);
    end
    bus.rq1_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
  endtask

  task automatic test_bad_type();
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h77; bus.rq0_type = 2'b11; bus.rq0_write = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata} !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL bad_type: got sel=%b rdy=%b err=%b rdata=%h want 0 1 1 00",
                        bus.mem_select, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata);
    end
    bus.rq0_req = 1'b0; bus.rq0_type = 2'b01;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.rq0_ready} !== 2'b00) begin
      n_bad++; $display("FAIL bad_type_after: got sel=%b rdy=%b want 0 0", bus.mem_select, bus.rq0_ready);
    end
  endtask

`ifdef SPELL_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h55; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    tick();
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_select === 1'b1) hi++;
      if (i == 7) begin
        bus.mem_data_ready = 1'b1; bus.mem_data_out = 8'h77;
      end
      tick();
    end
    n_cmp++;
    if ({hi[3:0], bus.rq0_ready, bus.rq0_err, bus.rq0_rdata} !== {4'd8, 1'b1, 1'b0, 8'h77}) begin
      n_bad++; $display("FAIL tmo_race: got hi=%0d rdy=%b err=%b rdata=%h want 8 1 0 77",
                        hi, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata);
    end
    bus.rq0_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
    bus.rq0_req = 1'b1;
    tick();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_select !== 1'b1) break;
      hi++;
      tick();
    end
    n_cmp++;
    if ({hi[4:0], bus.rq0_ready, bus.rq0_err, bus.rq0_rdata} !== {5'd8, 1'b1, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL tmo_abort: got hi=%0d rdy=%b err=%b rdata=%h want 8 1 1 00",
                        hi, bus.rq0_ready, bus.rq0_err, bus.rq0_rdata);
    end
    bus.rq0_req = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h55; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    tick();
    repeat (20) tick();
    n_cmp++;
    if ({bus.mem_select, bus.rq0_ready} !== 2'b10) begin
      n_bad++; $display("FAIL wait_forever: got sel=%b rdy=%b want 1 0", bus.mem_select, bus.rq0_ready);
    end
    bus.mem_data_ready = 1'b1; bus.mem_data_out = 8'h66;
    tick();
    n_cmp++;
    if ({bus.rq0_ready, bus.rq0_err, bus.rq0_rdata} !== {1'b1, 1'b0, 8'h66}) begin
      n_bad++; $display("FAIL late_resp: got rdy=%b err=%b rdata=%h want 1 0 66",
                        bus.rq0_ready, bus.rq0_err, bus.rq0_rdata);
    end
    bus.rq0_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    bus.rq0_req = 1'b1; bus.rq0_addr = 8'h11; bus.rq0_type = 2'b01; bus.rq0_write = 1'b0;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.mem_select !== 1'b1) begin
      n_bad++; $display("FAIL mid_access: sel got %b want 1", bus.mem_select);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_select, bus.mem_addr, bus.rq0_ready, bus.rq1_ready} !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got sel=%b addr=%h rdy0=%b rdy1=%b want all 0",
                        bus.mem_select, bus.mem_addr, bus.rq0_ready, bus.rq1_ready);
    end
    bus.rq1_req = 1'b1; bus.rq1_addr = 8'h22; bus.rq1_type = 2'b01; bus.rq1_write = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.rq0_ready, bus.rq1_ready} !== 3'b000) begin
      n_bad++; $display("FAIL in_reset: got sel=%b rdy0=%b rdy1=%b want 0 0 0",
                        bus.mem_select, bus.rq0_ready, bus.rq1_ready);
    end
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.mem_addr} !== {1'b1, 8'h11}) begin
      n_bad++; $display("FAIL post_reset_grant: got sel=%b addr=%h want 1 11", bus.mem_select, bus.mem_addr);
    end
    bus.mem_data_ready = 1'b1; bus.mem_data_out = 8'h5A;
    tick();
    n_cmp++;
    if ({bus.rq0_ready, bus.rq0_rdata, bus.rq1_ready} !== {1'b1, 8'h5A, 1'b0}) begin
      n_bad++; $display("FAIL post_reset_resp: got rdy0=%b rdata0=%h rdy1=%b want 1 5a 0",
                        bus.rq0_ready, bus.rq0_rdata, bus.rq1_ready);
    end
    bus.rq0_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus.mem_select, bus.mem_addr} !== {1'b1, 8'h22}) begin
      n_bad++; $display("FAIL post_reset_port1: got sel=%b addr=%h want 1 22", bus.mem_select, bus.mem_addr);
    end
    bus.mem_data_ready = 1'b1; bus.mem_data_out = 8'h3D;
    tick();
    n_cmp++;
    if ({bus.rq1_ready, bus.rq1_rdata} !== {1'b1, 8'h3D}) begin
      n_bad++; $display("FAIL post_reset_port1_resp: got rdy1=%b rdata1=%h want 1 3d", bus.rq1_ready, bus.rq1_rdata);
    end
    bus.rq1_req = 1'b0; bus.mem_data_ready = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clock);
    test_reset();
    test_single_read();
    test_contention();
    test_write_latency();
    test_bad_type();
`ifdef SPELL_MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spell_mem_arbiter.md
# spell_mem_arbiter

Two-port arbiter and sequencer for the spell memory port (spell_mem). It sits between the spell core (port 0) and the debug/program-loader interface (port 1). It grants the single memory port to one requester at a time and drives the registered select/addr/data/type/write bundle. It holds that bundle until the memory raises data_ready, then returns the read data and a one-cycle ready pulse to the winning requester.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 64: cycles in ACCESS before a transaction is aborted. Used only with SPELL_MEM_ARB_TIMEOUT_EN. Legal range 1..255.

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- rq0_req / rq1_req  in  1  request, held stable until matching ready
- rq0_addr / rq1_addr  in  8  memory address
- rq0_wdata / rq1_wdata  in  8  write data
- rq0_type / rq1_type  in  2  memory type, `MemoryTypeCode or `MemoryTypeData
- rq0_write / rq1_write  in  1  1 = write
- rq0_rdata / rq1_rdata  out  8  read data, registered
- rq0_ready / rq1_ready  out  1  one-cycle completion pulse
- rq0_err / rq1_err  out  1  valid with ready; bad type or timeout
- mem_select, mem_write  out  1  to spell_mem
- mem_addr, mem_data_in  out  8  to spell_mem
- mem_memory_type  out  2  to spell_mem
- mem_data_out  in  8  from spell_mem
- mem_data_ready  in  1  from spell_mem

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE**
  - If no request, stay in IDLE.
  - If one request, grant it.
  - If both requests, grant the port not granted last (round-robin). The last_grant flag resets to 1, so port 0 wins the first contention.
  - On grant: latch the requester's addr, wdata, type and write into the mem_* registers; set mem_select=1; go to ACCESS.
  - Bad type (neither `MemoryTypeCode nor `MemoryTypeData): do not assert mem_select; go straight to RESP with err=1 and rdata=0. last_grant still updates.
- **ACCESS**
  - Hold all mem_* outputs stable.
  - When mem_data_ready=1: clear mem_select. On a read, latch mem_data_out into the granted port's rdata; on a write, rdata holds its value. Set ready and err=0, then go to RESP.
- **RESP**
  - The granted port's ready is high for exactly this cycle.
  - No arbitration happens in RESP, so a requester whose req is still high this cycle is not re-granted.
  - Always go to IDLE next.
- mem_data_ready outside ACCESS is ignored.
- Changes to rq*_ inputs while a port is granted are ignored; values are taken only at grant.
- The non-granted port's outputs hold their values, and its ready stays 0.

## Timing
- Reset values: mem_select=0, mem_write=0, mem_addr=0, mem_data_in=0, mem_memory_type=0, all rdata=0, all ready=0, all err=0, state=IDLE, last_grant=1.
- Request sampled at edge N → mem_select high after edge N.
- mem_data_ready sampled high at edge M → mem_select low, and ready/rdata valid after edge M.
- Minimum request-to-ready latency is 2 cycles, with a zero-wait memory.
- Minimum spacing between grants is 3 cycles: IDLE, ACCESS, RESP.
- Bad-type request: ready 1 cycle after sampling.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronously). The transaction is lost and no ready is issued.

## Configuration
- SPELL_MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering ACCESS and increments each ACCESS cycle.
  - When the count reaches TIMEOUT_CYCLES with no data_ready, mem_select drops, rdata=0, err=1, and the arbiter goes to RESP.
  - If data_ready and timeout occur on the same cycle, data_ready wins (err=0).
- Not defined: no counter; ACCESS waits indefinitely; err is raised only for bad type.

## Structure
- Shared spell package/header:
  - State encoding localparams (SPELL_ARB_IDLE/ACCESS/RESP).
  - Reuse the existing `MemoryTypeCode/`MemoryTypeData definitions; no new type constants.
- One sub-module, spell_mem_arb_rr:
  - Combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant. Outputs: grant_valid, grant_idx.

## Test plan
- Port 0 reads Data addr 0x10 and memory returns 0xA5 with data_ready on the first ACCESS cycle → mem_select high for 1 cycle; rq0_ready pulses 2 cycles after req; rq0_rdata=0xA5; rq0_err=0.
- Both ports request together after reset, and each holds req for a second access → grant order 0, 1, 0, 1; each ready is a single pulse; no back-to-back regrant in RESP.
- Port 1 writes Code addr 0x42, data 0x3C, with memory latency 4 cycles → mem_addr=0x42, mem_data_in=0x3C, mem_write=1, all stable for 4 cycles; rq1_ready follows; rq1_rdata unchanged.
- Port 0 request with type 2'b11 → mem_select never rises; rq0_ready and rq0_err=1 one cycle later; rq0_rdata=0.
- With SPELL_MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds → mem_select high for 8 cycles, then rq0_err=1 and rq0_ready=1. Repeat with data_ready arriving on cycle 8 → err=0.
- Reset asserted on the 3rd ACCESS cycle → mem_select drops without a clock edge; no ready issued; next request proceeds normally with port 0 winning contention.
